// File: rtl/dbg_pkg.sv
// Shared constants for the debug-monitor link: command bytes, reply ASCII, FSM encoding, hex helper.
package dbg_pkg;

  localparam logic [7:0] CMD_PC     = 8'h50; // 'P'
  localparam logic [7:0] CMD_INST   = 8'h49; // 'I'
  localparam logic [7:0] CMD_ALU    = 8'h41; // 'A'
  localparam logic [7:0] CMD_MEM    = 8'h4D; // 'M'
  localparam logic [7:0] CMD_STATUS = 8'h53; // 'S'
  localparam logic [7:0] CMD_HALT   = 8'h48; // 'H'
  localparam logic [7:0] CMD_GO     = 8'h47; // 'G'

  // Clearing bit 5 folds lowercase letters onto uppercase.
  localparam logic [7:0] CASE_MASK  = 8'hDF;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_QM   = 8'h3F;
  localparam logic [7:0] ASCII_K    = 8'h4B;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_SEND    = 3'd2;
  localparam logic [2:0] ST_GUARD   = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_debug_responder.sv
// Single-byte command monitor answering with ASCII-hex probe snapshots; first tx_we 2 cycles after rx_re.
// Backpressure: waits on tx_busy per byte with no timeout; rx bytes are only consumed in IDLE.
module uart_debug_responder
  import dbg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter bit ECHO_EN = 1'b0,
  parameter bit CRLF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_re,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_busy,
  input  logic [DATA_W-1:0] probe_pc,
  input  logic [DATA_W-1:0] probe_inst,
  input  logic [DATA_W-1:0] probe_alu,
  input  logic [DATA_W-1:0] probe_mem,
  input  logic [7:0]        probe_status,
  output logic              halt_req,
  output logic              busy
);

  localparam int NIB     = DATA_W / 4;
  localparam int MAX_LEN = 1 + NIB + 2;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] PRE_LEN  = ECHO_EN ? CNT_W'(1) : CNT_W'(0);
  localparam logic [CNT_W-1:0] TAIL_LEN = CRLF_EN ? CNT_W'(2) : CNT_W'(0);
  localparam logic [CNT_W-1:0] HEX_LEN  = CNT_W'(NIB);

  logic [2:0]        state;
  logic [7:0]        cmd_q;
  logic [7:0]        cmd_uc;
  logic [DATA_W-1:0] shift_q;
  logic              pay_hex_q;
  logic [7:0]        pay_char_q;
  logic [CNT_W-1:0]  pay_len_q;
  logic [CNT_W-1:0]  char_idx;
  logic [CNT_W-1:0]  pay_end;
  logic [CNT_W-1:0]  reply_len;
  logic [7:0]        next_char;
  logic              in_payload;

  assign cmd_uc    = cmd_q & CASE_MASK;
  assign pay_end   = PRE_LEN + pay_len_q;
  assign reply_len = pay_end + TAIL_LEN;
  assign busy      = (state != ST_IDLE);

  // Reply byte selected by position: [echo] payload [CR LF].
  always_comb begin
    next_char  = ASCII_LF;
    in_payload = 1'b0;
    if (ECHO_EN && (char_idx == '0)) begin
      next_char = cmd_q;
    end else if (char_idx < pay_end) begin
      in_payload = 1'b1;
      next_char  = pay_hex_q ? nib2ascii(shift_q[DATA_W-1 -: 4]) : pay_char_q;
    end else if (char_idx == pay_end) begin
      next_char = ASCII_CR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_q      <= 8'h00;
      shift_q    <= '0;
      pay_hex_q  <= 1'b0;
      pay_char_q <= 8'h00;
      pay_len_q  <= '0;
      char_idx   <= '0;
      rx_re      <= 1'b0;
      tx_we      <= 1'b0;
      tx_data    <= 8'h00;
      halt_req   <= 1'b0;
    end else begin
      rx_re <= 1'b0;
      tx_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          char_idx <= '0;
          if (rx_valid) begin
            rx_re <= 1'b1;
            cmd_q <= rx_data;
            state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          pay_hex_q  <= 1'b1;
          pay_char_q <= ASCII_QM;
          pay_len_q  <= HEX_LEN;
          case (cmd_uc)
            CMD_PC:   shift_q <= probe_pc;
            CMD_INST: shift_q <= probe_inst;
            CMD_ALU:  shift_q <= probe_alu;
            CMD_MEM:  shift_q <= probe_mem;
            CMD_STATUS: begin
              shift_q   <= {probe_status, {(DATA_W-8){1'b0}}};
              pay_len_q <= CNT_W'(2);
            end
            CMD_HALT, CMD_GO: begin
              halt_req   <= (cmd_uc == CMD_HALT);
              pay_hex_q  <= 1'b0;
              pay_char_q <= ASCII_K;
              pay_len_q  <= CNT_W'(1);
            end
            default: begin
              pay_hex_q <= 1'b0;
              pay_len_q <= CNT_W'(1);
            end
          endcase
          state <= ST_SEND;
        end

        ST_SEND: begin
          if (!tx_busy) begin
            tx_data  <= next_char;
            tx_we    <= 1'b1;
            char_idx <= char_idx + CNT_W'(1);
            if (in_payload && pay_hex_q) begin
              shift_q <= shift_q << 4;
            end
            state <= ST_GUARD;
          end
        end

        // The uart raises tx_busy a cycle late, so it is not trusted here.
        ST_GUARD: state <= ST_WAIT_TX;

        ST_WAIT_TX: begin
          if (!tx_busy) begin
            state <= (char_idx < reply_len) ? ST_SEND : ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
